// File: rtl/spi_keys_host.sv
// SPI mode-0 master that polls a keyboard scanner one 8-key group per transaction
// and commits the assembled key bitmap atomically once every group has been read.
module spi_keys_host #(
    parameter int NUM_KEYS    = 61,
    parameter int CLK_DIV     = 4,
    parameter int CS_GAP      = 2,
    parameter int SCAN_PERIOD = 12000
) (
    input  logic                clk_g_i,
    input  logic                rst_g_i,
    input  logic                en_i,
    input  logic                scan_req_i,
    output logic                spi_clk_o,
    output logic                spi_mosi_o,
    input  logic                spi_miso_i,
    output logic                spi_cs_o,
    output logic [NUM_KEYS-1:0] keys_o,
    output logic                keys_valid_o,
    output logic                scan_done_o,
    output logic                keys_changed_o,
    output logic                busy_o
);
    localparam int GROUPS  = (NUM_KEYS + 7) / 8;
    localparam int GRP_W   = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam int CNT_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int TMR_W   = $clog2(SCAN_PERIOD);

    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(CS_GAP - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(SCAN_PERIOD - 1);
    localparam logic [GRP_W-1:0] GRP_LAST = GRP_W'(GROUPS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CS_SETUP,
        S_SHIFT,
        S_CS_HOLD,
        S_GAP,
        S_COMMIT
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [CNT_W-1:0]    r_cnt;
    logic [4:0]          r_bit;
    logic [GRP_W-1:0]    r_group;
    logic [GRP_W-1:0]    w_group_next;
    logic [TMR_W-1:0]    r_timer;
    logic                r_pending;
    logic                r_sck;
    logic                r_cs;
    logic [15:0]         r_tx;
    logic [7:0]          r_rx;
    logic [NUM_KEYS-1:0] r_shadow;
    logic [NUM_KEYS-1:0] r_keys;
    logic                r_valid;
    logic                r_done;
    logic                r_changed;

    logic w_cnt_last;
    logic w_start;
    logic w_load;
    logic w_rise;
    logic w_fall;
    logic w_store;
    logic w_commit;

    // NOTE: every combinational output gets a default first, so no path infers a latch.
    always_comb begin
        w_state_next = r_state;
        w_group_next = r_group;
        w_start      = 1'b0;
        w_load       = 1'b0;
        w_rise       = 1'b0;
        w_fall       = 1'b0;
        w_store      = 1'b0;
        w_commit     = 1'b0;
        w_cnt_last   = (r_state == S_GAP) ? (r_cnt == GAP_LAST) : (r_cnt == DIV_LAST);
        case (r_state)
            S_IDLE: begin
                if (scan_req_i || r_pending || (en_i && r_timer == TMR_LAST)) begin
                    w_state_next = S_CS_SETUP;
                    w_group_next = '0;
                    w_start      = 1'b1;
                    w_load       = 1'b1;
                end
            end
            S_CS_SETUP: begin
                if (w_cnt_last) begin
                    w_state_next = S_SHIFT;
                    w_rise       = 1'b1;
                end
            end
            S_SHIFT: begin
                // r_bit counts completed falling edges; 16 of them closes the frame.
                if (w_cnt_last) begin
                    if (r_sck)               w_fall       = 1'b1;
                    else if (r_bit == 5'd16) w_state_next = S_CS_HOLD;
                    else                     w_rise       = 1'b1;
                end
            end
            S_CS_HOLD: begin
                if (w_cnt_last) begin
                    w_state_next = S_GAP;
                    w_store      = 1'b1;
                end
            end
            S_GAP: begin
                if (w_cnt_last) begin
                    if (r_group == GRP_LAST) begin
                        w_state_next = S_COMMIT;
                    end else begin
                        w_state_next = S_CS_SETUP;
                        w_group_next = r_group + 1'b1;
                        w_load       = 1'b1;
                    end
                end
            end
            S_COMMIT: begin
                w_state_next = S_IDLE;
                w_commit     = 1'b1;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk_g_i) begin
        if (rst_g_i) r_state <= S_IDLE;
        else         r_state <= w_state_next;
    end

    always_ff @(posedge clk_g_i) begin
        if (rst_g_i) begin
            r_cnt     <= '0;
            r_bit     <= '0;
            r_group   <= '0;
            r_timer   <= '0;
            r_pending <= 1'b0;
            r_sck     <= 1'b0;
            r_cs      <= 1'b1;
            r_tx      <= '0;
            r_rx      <= '0;
            // NOTE: the shadow is cleared so an aborted scan can never leak into keys_o.
            r_shadow  <= '0;
            r_keys    <= '0;
            r_valid   <= 1'b0;
            r_done    <= 1'b0;
            r_changed <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_changed <= 1'b0;
            r_cnt     <= (r_state == S_IDLE || r_state == S_COMMIT || w_cnt_last) ? '0 : r_cnt + 1'b1;
            r_cs      <= !(w_state_next inside {S_CS_SETUP, S_SHIFT, S_CS_HOLD});
            r_group   <= w_group_next;

            if (w_start) begin
                r_timer   <= '0;
                r_pending <= 1'b0;
            end else begin
                if (r_state == S_IDLE && en_i)       r_timer   <= r_timer + 1'b1;
                if (r_state != S_IDLE && scan_req_i) r_pending <= 1'b1;
            end

            if (w_load) begin
                r_tx  <= {8'(w_group_next), 8'h00};
                r_bit <= '0;
            end
            if (w_rise) begin
                r_sck <= 1'b1;
                r_rx  <= {r_rx[6:0], spi_miso_i};
            end
            if (w_fall) begin
                r_sck <= 1'b0;
                r_tx  <= {r_tx[14:0], 1'b0};
                r_bit <= r_bit + 1'b1;
            end

            // Keys past NUM_KEYS in the last group have no slot and are dropped.
            if (w_store) begin
                for (int k = 0; k < NUM_KEYS; k++) begin
                    if (k / 8 == int'(r_group)) r_shadow[k] <= r_rx[k % 8];
                end
            end

            if (w_commit) begin
                r_keys    <= r_shadow;
                r_valid   <= 1'b1;
                r_done    <= 1'b1;
                r_changed <= (r_shadow != r_keys);
            end
        end
    end

    assign spi_clk_o      = r_sck;
    assign spi_mosi_o     = r_tx[15];
    assign spi_cs_o       = r_cs;
    assign keys_o         = r_keys;
    assign keys_valid_o   = r_valid;
    assign scan_done_o    = r_done;
    assign keys_changed_o = r_changed;
    assign busy_o         = (r_state != S_IDLE);

endmodule

// File: tb/tb_spi_keys_host.sv
// Bench for spi_keys_host: SPI slave model serving per-group bytes, a scoreboard of
// expected commits derived from the slave contents, and timing checks on scans.
module tb_spi_keys_host;
    localparam int NUM_KEYS    = 61;
    localparam int CLK_DIV     = 4;
    localparam int CS_GAP      = 2;
    localparam int SCAN_PERIOD = 200;
    localparam int GROUPS      = (NUM_KEYS + 7) / 8;
    localparam int AW          = $clog2(GROUPS);
    localparam int TXN_LEN     = 34 * CLK_DIV + CS_GAP;
    localparam int SCAN_LEN    = GROUPS * TXN_LEN + 1;

    logic                clk_g_i    = 1'b0;
    logic                rst_g_i    = 1'b1;
    logic                en_i       = 1'b0;
    logic                scan_req_i = 1'b0;
    logic                spi_clk_o;
    logic                spi_mosi_o;
    logic                spi_miso_i = 1'b0;
    logic                spi_cs_o;
    logic [NUM_KEYS-1:0] keys_o;
    logic                keys_valid_o;
    logic                scan_done_o;
    logic                keys_changed_o;
    logic                busy_o;

    spi_keys_host #(
        .NUM_KEYS   (NUM_KEYS),
        .CLK_DIV    (CLK_DIV),
        .CS_GAP     (CS_GAP),
        .SCAN_PERIOD(SCAN_PERIOD)
    ) dut (
        .clk_g_i       (clk_g_i),
        .rst_g_i       (rst_g_i),
        .en_i          (en_i),
        .scan_req_i    (scan_req_i),
        .spi_clk_o     (spi_clk_o),
        .spi_mosi_o    (spi_mosi_o),
        .spi_miso_i    (spi_miso_i),
        .spi_cs_o      (spi_cs_o),
        .keys_o        (keys_o),
        .keys_valid_o  (keys_valid_o),
        .scan_done_o   (scan_done_o),
        .keys_changed_o(keys_changed_o),
        .busy_o        (busy_o)
    );

    always #5 clk_g_i = ~clk_g_i;

    int cyc = 0;
    always @(posedge clk_g_i) cyc++;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- SPI slave model ----------------
    logic [7:0] slave_mem [GROUPS];
    logic [7:0] s_addr    = '0;
    logic [7:0] s_lo      = '0;
    logic [7:0] s_data    = '0;
    int         s_bit     = 0;
    int         win_idx   = 0;
    int         n_cs_fall = 0;
    int         start_cyc = 0;

    always @(negedge spi_cs_o) begin
        s_bit      = 0;
        s_addr     = '0;
        s_lo       = '0;
        spi_miso_i = 1'b0;
        n_cs_fall++;
        if (win_idx == 0) start_cyc = cyc;
    end

    always @(posedge spi_clk_o) begin
        if (spi_cs_o === 1'b0) begin
            if (s_bit < 8) s_addr = {s_addr[6:0], spi_mosi_o};
            else           s_lo   = {s_lo[6:0], spi_mosi_o};
            s_bit++;
        end
    end

    always @(negedge spi_clk_o) begin
        if (spi_cs_o === 1'b0) begin
            if (s_bit == 8) s_data = (s_addr < 8'(GROUPS)) ? slave_mem[s_addr[AW-1:0]] : 8'h00;
            if (s_bit >= 8 && s_bit < 16) begin
                spi_miso_i = s_data[7];
                s_data     = {s_data[6:0], 1'b0};
            end else begin
                spi_miso_i = 1'b0;
            end
        end
    end

    always @(posedge spi_cs_o) begin
        if (rst_g_i) begin
            win_idx = 0;
        end else begin
            check("win_sck_rises", 64'(s_bit), 64'(16));
            check("win_mosi_addr", 64'(s_addr), 64'(win_idx));
            check("win_mosi_low_byte", 64'(s_lo), 64'(0));
            win_idx = (win_idx + 1) % GROUPS;
        end
    end

    // ---------------- reference model + scoreboard ----------------
    typedef struct {
        logic [NUM_KEYS-1:0] keys;
        logic                changed;
    } exp_t;

    exp_t                exp_q[$];
    exp_t                mon_e;
    logic [NUM_KEYS-1:0] model_keys = '0;
    int                  n_done     = 0;

    task automatic expect_scan();
        logic [8*GROUPS-1:0] full;
        exp_t                e;
        for (int g = 0; g < GROUPS; g++) full[g*8 +: 8] = slave_mem[g];
        e.keys    = full[NUM_KEYS-1:0];
        e.changed = (e.keys != model_keys);
        model_keys = e.keys;
        exp_q.push_back(e);
    endtask

    always @(negedge clk_g_i) begin
        if (keys_changed_o === 1'b1) check("changed_with_done", 64'(scan_done_o), 64'(1));
        if (scan_done_o === 1'b1) begin
            n_done++;
            check("done_expected", 64'(exp_q.size() > 0), 64'(1));
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("keys", 64'(keys_o), 64'(mon_e.keys));
                check("keys_changed", 64'(keys_changed_o), 64'(mon_e.changed));
                check("keys_valid", 64'(keys_valid_o), 64'(1));
                check("scan_length", 64'(cyc - start_cyc), 64'(SCAN_LEN));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic randomize_slave();
        for (int g = 0; g < GROUPS; g++) slave_mem[g] = 8'($urandom_range(0, 255));
    endtask

    task automatic pulse_req();
        @(negedge clk_g_i);
        scan_req_i = 1'b1;
        @(negedge clk_g_i);
        scan_req_i = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int k = 0;
        while (scan_done_o !== 1'b1 && k < 2 * SCAN_LEN) begin
            @(negedge clk_g_i);
            k++;
        end
        check(name, 64'(scan_done_o === 1'b1), 64'(1));
    endtask

    task automatic wait_cs_fall(input string name);
        int k = 0;
        while (spi_cs_o !== 1'b0 && k < 4 * SCAN_PERIOD) begin
            @(negedge clk_g_i);
            k++;
        end
        check(name, 64'(spi_cs_o === 1'b0), 64'(1));
    endtask

    task automatic run_scan(input string name);
        expect_scan();
        pulse_req();
        wait_done(name);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int saved;
        int c0;

        // 1: reset state, then a requested scan with A0+g per group
        repeat (3) @(negedge clk_g_i);
        check("rst_cs", 64'(spi_cs_o), 64'(1));
        check("rst_sck", 64'(spi_clk_o), 64'(0));
        check("rst_mosi", 64'(spi_mosi_o), 64'(0));
        check("rst_keys", 64'(keys_o), 64'(0));
        check("rst_valid", 64'(keys_valid_o), 64'(0));
        check("rst_done", 64'(scan_done_o), 64'(0));
        check("rst_changed", 64'(keys_changed_o), 64'(0));
        check("rst_busy", 64'(busy_o), 64'(0));
        rst_g_i = 1'b0;
        for (int g = 0; g < GROUPS; g++) slave_mem[g] = 8'hA0 + 8'(g);
        run_scan("t1_done");
        check("t1_keys_55_0", 64'(keys_o[55:0]), 64'(56'hA6A5A4A3A2A1A0));
        check("t1_keys_60_56", 64'(keys_o[60:56]), 64'(5'h07));
        @(negedge clk_g_i);
        check("t1_done_one_cycle", 64'(scan_done_o), 64'(0));

        // 2: top group all ones, only the in-range bits land
        for (int g = 0; g < GROUPS; g++) slave_mem[g] = 8'h00;
        slave_mem[GROUPS-1] = 8'hFF;
        run_scan("t2_done");
        check("t2_keys", 64'(keys_o), 64'({5'h1F, 56'h0}));

        // 3: identical back-to-back scans, then a few random ones
        randomize_slave();
        run_scan("t3_first");
        run_scan("t3_repeat");
        check("t3_valid_stays", 64'(keys_valid_o), 64'(1));
        for (int i = 0; i < 4; i++) begin
            if (i != 2) randomize_slave();
            run_scan("t3_random");
        end

        // 4: several requests while busy collapse into one follow-up scan
        randomize_slave();
        expect_scan();
        expect_scan();
        pulse_req();
        check("t4_busy", 64'(busy_o), 64'(1));
        for (int i = 0; i < 3; i++) begin
            repeat (50) @(negedge clk_g_i);
            pulse_req();
        end
        wait_done("t4_first");
        check("t4_idle_after_commit", 64'(busy_o), 64'(0));
        @(negedge clk_g_i);
        check("t4_followup_cs", 64'(spi_cs_o), 64'(0));
        check("t4_followup_busy", 64'(busy_o), 64'(1));
        wait_done("t4_second");
        saved = n_cs_fall;
        repeat (SCAN_LEN + 300) @(negedge clk_g_i);
        check("t4_single_followup", 64'(n_cs_fall), 64'(saved));
        check("t4_idle_end", 64'(busy_o), 64'(0));

        // 5: periodic auto-scan, then disable in IDLE
        randomize_slave();
        expect_scan();
        c0 = cyc;
        en_i = 1'b1;
        wait_cs_fall("t5_first_start");
        check("t5_first_period", 64'(cyc - c0), 64'(SCAN_PERIOD));
        wait_done("t5_first_done");
        c0 = cyc;
        randomize_slave();
        expect_scan();
        wait_cs_fall("t5_second_start");
        check("t5_second_period", 64'(cyc - c0), 64'(SCAN_PERIOD));
        wait_done("t5_second_done");
        en_i = 1'b0;
        saved = n_cs_fall;
        repeat (3 * SCAN_PERIOD) @(negedge clk_g_i);
        check("t5_no_scan_disabled", 64'(n_cs_fall), 64'(saved));

        // 6: reset during SHIFT of group 3 aborts the scan
        randomize_slave();
        pulse_req();
        begin
            int k = 0;
            while (!(win_idx == 3 && spi_cs_o === 1'b0 && spi_clk_o === 1'b1) && k < SCAN_LEN) begin
                @(negedge clk_g_i);
                k++;
            end
            check("t6_reached_group3", 64'(win_idx == 3 && spi_clk_o === 1'b1), 64'(1));
        end
        rst_g_i = 1'b1;
        @(negedge clk_g_i);
        rst_g_i = 1'b0;
        check("t6_cs", 64'(spi_cs_o), 64'(1));
        check("t6_sck", 64'(spi_clk_o), 64'(0));
        check("t6_keys", 64'(keys_o), 64'(0));
        check("t6_valid", 64'(keys_valid_o), 64'(0));
        check("t6_busy", 64'(busy_o), 64'(0));
        model_keys = '0;
        saved = n_done;
        repeat (SCAN_LEN + 200) @(negedge clk_g_i);
        check("t6_no_done", 64'(n_done), 64'(saved));
        randomize_slave();
        slave_mem[0] = slave_mem[0] | 8'h01;
        run_scan("t6_recover");

        repeat (5) @(negedge clk_g_i);
        check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
